pkt_rr_arb: RTL and testbench
=============================

PKT_RR_ARB -- requirements
Module: pkt_rr_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 64: TDATA width of every stream.
REQ-002 Parameter NUM_SRC, default 4: number of input streams, legal range 2..16.
REQ-003 Parameter ID_WIDTH, default 2: m_TID width; SHALL equal max(1, clog2(NUM_SRC)).
REQ-004 Parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  reset rst, synchronous, active-high; clock clk.
REQ-007 s_TDATA  in  NUM_SRC*DATA_WIDTH  input data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 s_TVALID  in  NUM_SRC  per-channel valid.
REQ-009 s_TREADY  out  NUM_SRC  per-channel ready.
REQ-010 s_TLAST  in  NUM_SRC  per-channel end of packet.
REQ-011 m_TDATA  out  DATA_WIDTH  output data.
REQ-012 m_TVALID  out  1  output valid.
REQ-013 m_TREADY  in  1  output ready.
REQ-014 m_TLAST  out  1  output end of packet.
REQ-015 m_TID  out  ID_WIDTH  index of the source channel of the current output flit.
REQ-016 busy  out  1  high while a packet is locked (state LOCKED).

Function
REQ-017 Flit transfer on any stream SHALL occur only on a cycle where VALID and READY are both high.
REQ-018 Arbiter states SHALL be IDLE and LOCKED, with a registered grant index gnt and a registered round-robin pointer ptr.
REQ-019 In IDLE with any s_TVALID high, the grant SHALL be chosen combinationally in the same cycle: ARB_MODE=0 -> first valid channel searching ptr, ptr+1, ... modulo NUM_SRC; ARB_MODE=1 -> lowest valid index.
REQ-020 s_TREADY[i] SHALL be high only for the granted channel (IDLE: combinational choice; LOCKED: gnt), and only when the output buffer has a free entry; all other bits SHALL be 0.
REQ-021 IDLE -> LOCKED when a granted flit with TLAST=0 is accepted; gnt SHALL latch the chosen index.
REQ-022 LOCKED -> IDLE when the gnt channel's TLAST flit is accepted; a single-flit packet (TLAST=1 accepted in IDLE) SHALL leave the state IDLE.
REQ-023 ptr SHALL update to (granted index + 1) modulo NUM_SRC on acceptance of each packet's first flit; ptr SHALL NOT change in ARB_MODE=1.
REQ-024 In LOCKED, grant SHALL NOT change regardless of other s_TVALID, including when the locked channel deasserts TVALID mid-packet.
REQ-025 The output SHALL be a 2-entry skid buffer holding {TDATA, TLAST, TID}; m_* outputs SHALL be driven directly from registers.
REQ-026 Latency: a flit accepted on s_* at cycle t SHALL be presented on m_* at cycle t+1 when the buffer was empty.
REQ-027 Sustained throughput SHALL be one flit per cycle with m_TREADY held high, including across packet boundaries (no bubble between a TLAST flit and the next packet's first flit).
REQ-028 The buffer ready term SHALL be registered (no combinational path m_TREADY -> s_TREADY).
REQ-029 When the buffer is full, s_TREADY SHALL be all 0 and m_* SHALL hold stable until m_TREADY.
REQ-030 Simultaneous push and pop with the buffer full SHALL NOT occur (push blocked); with one entry, push and pop together SHALL keep the count at one.
REQ-031 Output flit order SHALL equal acceptance order; packets from different channels SHALL never interleave on m_*.

Reset
REQ-032 With rst high at a clock edge: state=IDLE, gnt=0, ptr=0, buffer empty; next cycle m_TVALID=0, busy=0, s_TREADY=0 while rst is high.
REQ-033 rst asserted mid-packet SHALL discard buffered flits and the lock; after release, arbitration restarts from ptr=0 with no partial-packet tracking.
REQ-034 Registers SHALL carry no initial-value dependence; behaviour before the first reset is undefined.

Verification
REQ-035 NUM_SRC=4, ARB_MODE=0, all four channels continuously valid with 2-flit packets, m_TREADY=1 -> m_TID packet sequence 0,1,2,3,0,... at one flit per cycle.
REQ-036 ARB_MODE=1, channels 1 and 3 valid with 1-flit packets -> m_TID always 1 until channel 1 idles, then 3.
REQ-037 Channel 2 sends a 4-flit packet with a TVALID gap after flit 2 while channel 0 is valid -> no channel-0 flit appears until channel 2's TLAST has left; busy=1 throughout.
REQ-038 m_TREADY=0 for 5 cycles during a stream -> after 2 accepted flits all s_TREADY=0; m_TDATA stable; no flit lost or duplicated after release.
REQ-039 rst pulsed for 1 cycle mid-packet on channel 1 -> m_TVALID=0 and busy=0 the next cycle; channels 0 and 1 both valid afterwards -> channel 0 granted first.
REQ-040 Random VALID/READY/TLAST stress, 10000 cycles -> scoreboard per-channel flit order exact, no interleave, starvation bound NUM_SRC-1 packets in mode 0.

Source files
------------

// File: rtl/pkt_rr_arb.sv
// Packet-level stream arbiter: picks one of NUM_SRC input streams per packet
// (round-robin or fixed priority), holds the grant until TLAST, and forwards
// flits through a 2-entry skid buffer so every m_* output comes from a register.
module pkt_rr_arb #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned ARB_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_TDATA,
    input  logic [NUM_SRC-1:0]            s_TVALID,
    output logic [NUM_SRC-1:0]            s_TREADY,
    input  logic [NUM_SRC-1:0]            s_TLAST,
    output logic [DATA_WIDTH-1:0]         m_TDATA,
    output logic                          m_TVALID,
    input  logic                          m_TREADY,
    output logic                          m_TLAST,
    output logic [ID_WIDTH-1:0]           m_TID,
    output logic                          busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
    } flit_t;

    state_t              state_q;
    logic [ID_WIDTH-1:0] gnt_q;
    logic [ID_WIDTH-1:0] ptr_q;

    logic [ID_WIDTH-1:0] sel_c;
    logic [ID_WIDTH-1:0] idx_c;
    logic                req_c;
    logic                accept_c;
    logic                pop_c;
    flit_t               in_flit_c;

    logic [1:0]          count_q;
    logic [1:0]          count_d;
    logic                buf_rdy_q;
    logic                out_valid_q;
    flit_t               out_q;
    flit_t               skid_q;

    // Channel index a steps forward by b, wrapping at NUM_SRC (a < NUM_SRC, b <= NUM_SRC).
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] a,
                                                     input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s >= NUM_SRC) begin
            s = s - NUM_SRC;
        end
        return ID_WIDTH'(s);
    endfunction

    // Same-cycle choice in IDLE; the last hit in the descending scan is the winner.
    always_comb begin
        sel_c = ptr_q;
        if (ARB_MODE == 0) begin
            for (int unsigned k = NUM_SRC; k > 0; k--) begin
                if (s_TVALID[wrap_add(ptr_q, k - 1)]) begin
                    sel_c = wrap_add(ptr_q, k - 1);
                end
            end
        end else begin
            sel_c = '0;
            for (int unsigned k = NUM_SRC; k > 0; k--) begin
                if (s_TVALID[ID_WIDTH'(k - 1)]) begin
                    sel_c = ID_WIDTH'(k - 1);
                end
            end
        end
    end

    // Grant steering: ready goes only to the granted channel, gated by the registered buffer ready.
    always_comb begin
        idx_c    = (state_q == LOCKED) ? gnt_q : sel_c;
        req_c    = (state_q == LOCKED) || (|s_TVALID);
        s_TREADY = '0;
        if (buf_rdy_q && req_c) begin
            s_TREADY[idx_c] = 1'b1;
        end
        accept_c       = buf_rdy_q && req_c && s_TVALID[idx_c];
        in_flit_c.data = s_TDATA[32'(idx_c) * DATA_WIDTH +: DATA_WIDTH];
        in_flit_c.last = s_TLAST[idx_c];
        in_flit_c.id   = idx_c;
    end

    // Arbiter state: lock on a non-final first flit, unlock on the locked channel's TLAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else if (accept_c) begin
            if (state_q == IDLE) begin
                gnt_q <= sel_c;
                if (ARB_MODE == 0) begin
                    ptr_q <= wrap_add(sel_c, 1);
                end
                if (!in_flit_c.last) begin
                    state_q <= LOCKED;
                end
            end else if (in_flit_c.last) begin
                state_q <= IDLE;
            end
        end
    end

    assign pop_c = out_valid_q && m_TREADY;

    // Occupancy of the skid buffer after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({accept_c, pop_c})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Buffer control; the ready term is registered so m_TREADY never reaches s_TREADY combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            buf_rdy_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            out_valid_q <= (count_d != 2'd0);
            buf_rdy_q   <= (count_d != 2'd2);
        end
    end

    // Buffer payload: the output entry takes new data when empty or draining, else refills from skid.
    always_ff @(posedge clk) begin
        if (accept_c && ((count_q == 2'd0) || ((count_q == 2'd1) && pop_c))) begin
            out_q <= in_flit_c;
        end else if (pop_c && (count_q == 2'd2)) begin
            out_q <= skid_q;
        end
        if (accept_c && (count_q == 2'd1) && !pop_c) begin
            skid_q <= in_flit_c;
        end
    end

    assign m_TDATA  = out_q.data;
    assign m_TLAST  = out_q.last;
    assign m_TID    = out_q.id;
    assign m_TVALID = out_valid_q;
    assign busy     = (state_q == LOCKED);

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Directed and randomised checks of pkt_rr_arb in round-robin and fixed-priority modes.
module tb_pkt_rr_arb;

    localparam int DW = 16;
    localparam int NS = 4;
    localparam int IW = 2;
    localparam int STRESS = 10000;

    typedef struct packed {
        logic [IW-1:0] tid;
        logic          last;
        logic [DW-1:0] data;
    } flit_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NS*DW-1:0] sd0, sd1;
    logic [NS-1:0]    sv0, sv1, sl0, sl1, sr0, sr1;
    logic [DW-1:0]    md0, md1;
    logic             mv0, mv1, mr0, mr1, ml0, ml1, busy0, busy1;
    logic [IW-1:0]    mt0, mt1;

    pkt_rr_arb #(.DATA_WIDTH(DW), .NUM_SRC(NS), .ID_WIDTH(IW), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_TDATA(sd0), .s_TVALID(sv0), .s_TREADY(sr0), .s_TLAST(sl0),
        .m_TDATA(md0), .m_TVALID(mv0), .m_TREADY(mr0), .m_TLAST(ml0), .m_TID(mt0),
        .busy(busy0)
    );

    pkt_rr_arb #(.DATA_WIDTH(DW), .NUM_SRC(NS), .ID_WIDTH(IW), .ARB_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .s_TDATA(sd1), .s_TVALID(sv1), .s_TREADY(sr1), .s_TLAST(sl1),
        .m_TDATA(md1), .m_TVALID(mv1), .m_TREADY(mr1), .m_TLAST(ml1), .m_TID(mt1),
        .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    // Directed source model: channel i sends flits seq 0..lim-1, packets of len flits.
    int          dsel;
    bit [NS-1:0] en;
    int          len [NS];
    int          lim [NS];
    int          seq [NS];
    int          cyc_n;
    int          multi_rdy;
    flit_t       out_q [$];
    int          out_cyc [$];
    bit          lastmem [NS][16384];

    function automatic flit_t mk(input int ch, input int s, input bit last);
        return {IW'(ch), last, 4'(ch), 12'(s)};
    endfunction

    // One clock of the directed source/sink: drive, sample at negedge, advance at posedge.
    task automatic cyc();
        logic [NS-1:0]    v, l, r;
        logic [NS*DW-1:0] d;
        for (int i = 0; i < NS; i++) begin
            v[i] = en[i] && (seq[i] < lim[i]);
            l[i] = ((seq[i] % len[i]) == (len[i] - 1));
            d[i*DW +: DW] = {4'(i), 12'(seq[i])};
        end
        if (dsel == 0) begin
            sv0 = v; sl0 = l; sd0 = d; sv1 = '0;
        end else begin
            sv1 = v; sl1 = l; sd1 = d; sv0 = '0;
        end
        @(negedge clk);
        r = (dsel == 0) ? sr0 : sr1;
        if (!$onehot0(r)) multi_rdy++;
        for (int i = 0; i < NS; i++) begin
            if (v[i] && r[i]) seq[i]++;
        end
        if (dsel == 0) begin
            if (mv0 && mr0) begin out_q.push_back({mt0, ml0, md0}); out_cyc.push_back(cyc_n); end
        end else begin
            if (mv1 && mr1) begin out_q.push_back({mt1, ml1, md1}); out_cyc.push_back(cyc_n); end
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = '0;
        for (int i = 0; i < NS; i++) begin
            seq[i] = 0; len[i] = 1; lim[i] = 1000;
        end
        sv0 = '0; sv1 = '0; sl0 = '0; sl1 = '0; sd0 = '0; sd1 = '0;
        mr0 = 1'b1; mr1 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        out_q.delete();
        out_cyc.delete();
        multi_rdy = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mr0 = 1'b1; mr1 = 1'b1;
        sv0 = '1; sv1 = '1; sl0 = '0; sl1 = '0; sd0 = '0; sd1 = '0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (mv0 !== 1'b0)   begin errors++; $display("FAIL reset_m_valid0: got %b expected 0", mv0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
        checks++; if (sr0 !== 4'b0)   begin errors++; $display("FAIL reset_s_ready0: got %b expected 0000", sr0); end
        checks++; if (mv1 !== 1'b0)   begin errors++; $display("FAIL reset_m_valid1: got %b expected 0", mv1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
        checks++; if (sr1 !== 4'b0)   begin errors++; $display("FAIL reset_s_ready1: got %b expected 0000", sr1); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        flit_t e;
        do_reset();
        dsel = 0;
        en   = '1;
        for (int i = 0; i < NS; i++) len[i] = 2;
        repeat (24) cyc();
        checks++;
        if (out_q.size() < 16) begin errors++; $display("FAIL rr_count: got %0d flits expected >= 16", out_q.size()); end
        for (int k = 0; k < 16; k++) begin
            if (k < out_q.size()) begin
                e = mk((k / 2) % 4, (k / 8) * 2 + (k % 2), k % 2 == 1);
                checks++;
                if (out_q[k] !== e) begin errors++; $display("FAIL rr_flit%0d: got %h expected %h", k, out_q[k], e); end
            end
        end
        if (out_q.size() >= 16) begin
            checks++;
            if (out_cyc[15] - out_cyc[0] != 15) begin
                errors++; $display("FAIL rr_rate: 16 flits took %0d cycles expected 15", out_cyc[15] - out_cyc[0]);
            end
        end
        checks++;
        if (multi_rdy != 0) begin errors++; $display("FAIL rr_onehot_ready: got %0d multi-ready cycles expected 0", multi_rdy); end
    endtask

    task automatic test_fixed_priority();
        flit_t e;
        do_reset();
        dsel = 1;
        en   = 4'b1010;
        lim[1] = 3;
        repeat (12) cyc();
        for (int k = 0; k < 6; k++) begin
            e = (k < 3) ? mk(1, k, 1'b1) : mk(3, k - 3, 1'b1);
            checks++;
            if (k >= out_q.size() || out_q[k] !== e) begin
                errors++; $display("FAIL prio_flit%0d: got %h expected %h", k, (k < out_q.size()) ? out_q[k] : '0, e);
            end
        end
    endtask

    task automatic test_lock();
        int    n;
        flit_t e;
        do_reset();
        dsel = 0;
        en   = 4'b0100;
        len[2] = 4; lim[2] = 4;
        lim[0] = 2;
        n = 0; while (seq[2] < 1 && n < 10) begin cyc(); n++; end
        en[0] = 1'b1;
        n = 0; while (seq[2] < 2 && n < 10) begin cyc(); n++; end
        checks++;
        if (seq[2] < 2) begin errors++; $display("FAIL lock_timeout: got %0d flits accepted expected 2", seq[2]); end
        en[2] = 1'b0;
        repeat (3) begin
            cyc();
            checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL lock_busy_gap: got %b expected 1", busy0); end
            checks++; if (sr0 !== 4'b0100) begin errors++; $display("FAIL lock_ready_gap: got %b expected 0100", sr0); end
        end
        en[2] = 1'b1;
        n = 0; while (out_q.size() < 6 && n < 30) begin cyc(); n++; end
        checks++;
        if (out_q.size() < 6) begin errors++; $display("FAIL lock_count: got %0d flits expected 6", out_q.size()); end
        for (int k = 0; k < 6; k++) begin
            if (k < out_q.size()) begin
                e = (k < 4) ? mk(2, k, k == 3) : mk(0, k - 4, 1'b1);
                checks++;
                if (out_q[k] !== e) begin errors++; $display("FAIL lock_flit%0d: got %h expected %h", k, out_q[k], e); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] hold;
        flit_t         e;
        do_reset();
        dsel = 0;
        en   = 4'b0010;
        len[1] = 3;
        repeat (4) cyc();
        mr0 = 1'b0;
        cyc();
        hold = md0;
        repeat (4) begin
            checks++; if (sr0 !== 4'b0)  begin errors++; $display("FAIL bp_ready: got %b expected 0000", sr0); end
            checks++; if (mv0 !== 1'b1)  begin errors++; $display("FAIL bp_valid: got %b expected 1", mv0); end
            checks++; if (md0 !== hold)  begin errors++; $display("FAIL bp_data_stable: got %h expected %h", md0, hold); end
            cyc();
        end
        mr0 = 1'b1;
        repeat (6) cyc();
        en = '0;
        repeat (4) cyc();
        checks++;
        if (out_q.size() != seq[1]) begin errors++; $display("FAIL bp_count: got %0d flits expected %0d", out_q.size(), seq[1]); end
        for (int k = 0; k < out_q.size(); k++) begin
            e = mk(1, k, k % 3 == 2);
            checks++;
            if (out_q[k] !== e) begin errors++; $display("FAIL bp_flit%0d: got %h expected %h", k, out_q[k], e); end
        end
    endtask

    task automatic test_reset_mid();
        int    n;
        flit_t e;
        do_reset();
        dsel = 0;
        en   = 4'b0010;
        len[1] = 4;
        n = 0; while (seq[1] < 2 && n < 10) begin cyc(); n++; end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (mv0 !== 1'b0)   begin errors++; $display("FAIL rstmid_valid: got %b expected 0", mv0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy0); end
        out_q.delete();
        out_cyc.delete();
        for (int i = 0; i < NS; i++) seq[i] = 0;
        en = 4'b0011;
        n = 0; while (out_q.size() < 1 && n < 10) begin cyc(); n++; end
        e = mk(0, 0, 1'b1);
        checks++;
        if (out_q.size() < 1 || out_q[0] !== e) begin
            errors++; $display("FAIL rstmid_first: got %h expected %h", (out_q.size() > 0) ? out_q[0] : '0, e);
        end
    endtask

    task automatic test_stress();
        int rdn [NS];
        int wrn [NS];
        int wait_n [NS];
        bit bnd [NS];
        bit acc [NS];
        bit prev_last;
        int prev_tid;
        int max_wait;
        int t;
        do_reset();
        for (int i = 0; i < NS; i++) begin
            rdn[i] = 0; wrn[i] = 0; wait_n[i] = 0; bnd[i] = 1'b1; acc[i] = 1'b0;
        end
        prev_last = 1'b1; prev_tid = 0; max_wait = 0;
        for (int c = 0; c < STRESS + 60; c++) begin
            mr0 = (c >= STRESS) ? 1'b1 : ($urandom_range(3, 0) != 0);
            for (int i = 0; i < NS; i++) begin
                if (!sv0[i] && c < STRESS && $urandom_range(1, 0) == 1) begin
                    sv0[i] = 1'b1;
                    sl0[i] = ($urandom_range(2, 0) == 0);
                    sd0[i*DW +: DW] = {4'(i), 12'(wrn[i])};
                end
            end
            @(negedge clk);
            checks++;
            if (!$onehot0(sr0)) begin errors++; $display("FAIL st_onehot: got %b expected at most one bit", sr0); end
            for (int j = 0; j < NS; j++) begin
                acc[j] = sv0[j] && sr0[j];
                if (acc[j]) begin
                    if (bnd[j]) begin
                        for (int i = 0; i < NS; i++) begin
                            if (i != j && sv0[i] && bnd[i]) begin
                                wait_n[i]++;
                                if (wait_n[i] > max_wait) max_wait = wait_n[i];
                            end
                        end
                        wait_n[j] = 0;
                    end
                    lastmem[j][wrn[j]] = sl0[j];
                    wrn[j]++;
                    bnd[j] = sl0[j];
                end
            end
            if (mv0 && mr0) begin
                t = 32'(mt0);
                checks++;
                if (!prev_last && t != prev_tid) begin errors++; $display("FAIL st_interleave: got tid %0d expected %0d", t, prev_tid); end
                checks++;
                if (rdn[t] >= wrn[t] || md0 !== {4'(t), 12'(rdn[t])} || ml0 !== lastmem[t][rdn[t]]) begin
                    errors++; $display("FAIL st_order: ch %0d got data %h last %b expected seq %0d", t, md0, ml0, rdn[t]);
                end
                rdn[t]++;
                prev_last = ml0;
                prev_tid  = t;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (acc[i]) sv0[i] = 1'b0;
            end
        end
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (rdn[i] != wrn[i]) begin errors++; $display("FAIL st_drain_ch%0d: got %0d out expected %0d", i, rdn[i], wrn[i]); end
        end
        checks++;
        if (max_wait > NS - 1) begin errors++; $display("FAIL st_starve: got %0d packets waited expected <= %0d", max_wait, NS - 1); end
    endtask

    initial begin
        dsel = 0; cyc_n = 0; multi_rdy = 0; en = '0;
        for (int i = 0; i < NS; i++) begin seq[i] = 0; len[i] = 1; lim[i] = 1000; end
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_lock();
        test_backpressure();
        test_reset_mid();
        test_stress();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
